// File: rtl/multi_timer_pkg.sv
// Shared constants and types for the multi-channel prescaled down-counter timer.
package multi_timer_pkg;

    localparam int PRESC_W  = 10;

    localparam int DIV_1    = 1;
    localparam int DIV_8    = 8;
    localparam int DIV_64   = 64;
    localparam int DIV_1024 = 1024;

    localparam int A_CH_HI  = 5;
    localparam int A_CH_LO  = 4;
    localparam int A_MODE   = 3;
    localparam int A_IEN    = 2;
    localparam int A_SEL_HI = 1;
    localparam int A_SEL_LO = 0;
    localparam int A_STAT   = 0;

    typedef enum logic [1:0] {
        PRE_DIV1    = 2'b00,
        PRE_DIV8    = 2'b01,
        PRE_DIV64   = 2'b10,
        PRE_DIV1024 = 2'b11
    } presc_sel_e;

    typedef enum logic {
        MODE_ONE_SHOT    = 1'b0,
        MODE_AUTO_RELOAD = 1'b1
    } mode_e;

    // The prescaler stores div-1 so the tick compare needs no 11-bit value.
    function automatic logic [PRESC_W-1:0] presc_term(presc_sel_e sel);
        logic [PRESC_W-1:0] t;
        case (sel)
            PRE_DIV8:    t = PRESC_W'(DIV_8 - 1);
            PRE_DIV64:   t = PRESC_W'(DIV_64 - 1);
            PRE_DIV1024: t = PRESC_W'(DIV_1024 - 1);
            default:     t = PRESC_W'(DIV_1 - 1);
        endcase
        return t;
    endfunction

endpackage

// File: rtl/multi_timer_if.sv
// Register bus between a host and multi_timer: strobe, direction, address, data and interrupt.
interface multi_timer_if #(parameter int CNT_W = 8);
    logic             cs;
    logic             we_n;
    logic [5:0]       addr;
    logic [CNT_W-1:0] di;
    logic [CNT_W-1:0] dout;
    logic             oe;
    logic             irq_n;

    modport master (output cs, we_n, addr, di, input dout, oe, irq_n);
    modport slave  (input cs, we_n, addr, di, output dout, oe, irq_n);
endinterface

// File: rtl/timer_channel.sv
// One timer channel: prescaler, modulo down-counter with one-shot/auto-reload expiry,
// sticky expiry flag and interrupt enable.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_data_i,
    input  presc_sel_e       wr_sel_i,
    input  logic             wr_ien_i,
    input  mode_e            wr_mode_i,
    input  logic             rd_clr_i,
    input  logic             rd_ien_i,
    output logic [CNT_W-1:0] count_o,
    output logic             flag_o,
    output logic             ien_o
);

    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   reload_q, reload_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] term_q, term_d;
    logic               flag_q, flag_d;
    logic               ien_q, ien_d;
    mode_e              mode_q, mode_d;
    logic               armed_q, armed_d;
    logic               tick;
    logic               expire;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        term_d   = term_q;
        flag_d   = flag_q;
        ien_d    = ien_q;
        mode_d   = mode_q;
        armed_d  = armed_q;

        // Nothing counts until the channel has been written since reset.
        tick   = armed_q && (presc_q == term_q);
        expire = tick && (count_q == '0);

        if (armed_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else if (mode_q == MODE_AUTO_RELOAD) begin
                count_d = reload_q;
            end else begin
                count_d = '1;
                term_d  = presc_term(PRE_DIV1);
            end
        end

        if (expire) begin
            flag_d = 1'b1;
        end else if (rd_clr_i) begin
            flag_d = 1'b0;
        end
        if (rd_clr_i) begin
            ien_d = rd_ien_i;
        end

        if (wr_i) begin
            count_d  = wr_data_i;
            reload_d = wr_data_i;
            presc_d  = '0;
            term_d   = presc_term(wr_sel_i);
            ien_d    = wr_ien_i;
            mode_d   = wr_mode_i;
            flag_d   = 1'b0;
            armed_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            term_q   <= presc_term(PRE_DIV1);
            flag_q   <= 1'b0;
            ien_q    <= 1'b0;
            mode_q   <= MODE_ONE_SHOT;
            armed_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            term_q   <= term_d;
            flag_q   <= flag_d;
            ien_q    <= ien_d;
            mode_q   <= mode_d;
            armed_q  <= armed_d;
        end
    end

    assign count_o = count_q;
    assign flag_o  = flag_q;
    assign ien_o   = ien_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: bus decode, registered read mux and combined active-low interrupt
// around NUM_CH timer_channel instances.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    multi_timer_if.slave bus
);

    logic [1:0]       ch_sel;
    logic             ch_valid;
    logic             wr_en;
    logic             rd_en;
    logic [CNT_W-1:0] count_a [NUM_CH];
    logic [NUM_CH-1:0] flag_v;
    logic [NUM_CH-1:0] ien_v;

    logic [CNT_W-1:0] do_q, do_d;
    logic             oe_q, oe_d;
    logic             irq_n_q, irq_n_d;

    assign ch_sel   = bus.addr[A_CH_HI:A_CH_LO];
    assign ch_valid = (int'(ch_sel) < NUM_CH);
    assign wr_en    = bus.cs && !bus.we_n;
    assign rd_en    = bus.cs && bus.we_n;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;
        assign hit = ch_valid && (ch_sel == 2'(c));

        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_i      (wr_en && hit),
            .wr_data_i (bus.di),
            .wr_sel_i  (presc_sel_e'(bus.addr[A_SEL_HI:A_SEL_LO])),
            .wr_ien_i  (bus.addr[A_IEN]),
            .wr_mode_i (mode_e'(bus.addr[A_MODE])),
            .rd_clr_i  (rd_en && hit && !bus.addr[A_STAT]),
            .rd_ien_i  (bus.addr[A_IEN]),
            .count_o   (count_a[c]),
            .flag_o    (flag_v[c]),
            .ien_o     (ien_v[c])
        );
    end

    always_comb begin
        do_d    = do_q;
        oe_d    = 1'b0;
        irq_n_d = ~|(flag_v & ien_v);
        if (rd_en) begin
            oe_d = 1'b1;
            if (!ch_valid) begin
                do_d = '0;
            end else if (bus.addr[A_STAT]) begin
                do_d = CNT_W'(flag_v);
            end else begin
                do_d = count_a[ch_sel];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_q    <= '0;
            oe_q    <= 1'b0;
            irq_n_q <= 1'b1;
        end else begin
            do_q    <= do_d;
            oe_q    <= oe_d;
            irq_n_q <= irq_n_d;
        end
    end

    assign bus.dout  = do_q;
    assign bus.oe    = oe_q;
    assign bus.irq_n = irq_n_q;

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels (1..4).
REQ-002 Parameter CNT_W, default 8: counter and data-bus width (8..16).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cs  input  1  bus cycle strobe, one clk wide per access.
REQ-006 we_n  input  1  high = read, low = write, qualified by cs.
REQ-007 A  input  6  address: A[5:4] channel, A[3] mode, A[2] irq enable, A[1:0] prescale/register select.
REQ-008 DI  input  CNT_W  write data.
REQ-009 DO  output  CNT_W  registered read data.
REQ-010 OE  output  1  registered; high in the cycle DO carries valid read data.
REQ-011 irq_n  output  1  registered, active-low: OR over channels of flag & ien.

Function
REQ-012 Write (cs=1, we_n=0) to channel A[5:4]: next edge count<=DI, reload<=DI, prescale counter<=0, div per A[1:0] (00=1, 01=8, 10=64, 11=1024), ien<=A[2], mode<=A[3] (0 one-shot, 1 auto-reload), flag<=0.
REQ-013 A write to a channel index >= NUM_CH SHALL be ignored; a read of one SHALL return DO=0, OE=1.
REQ-014 Each channel asserts tick when its prescale counter equals div-1; prescale counter then returns to 0, otherwise increments.
REQ-015 On tick with count!=0: count<=count-1.
REQ-016 On tick with count==0, one-shot: flag<=1, count wraps to all-ones, div<=1 (counting continues at clk rate).
REQ-017 On tick with count==0, auto-reload: flag<=1, count<=reload, div unchanged.
REQ-018 Read (cs=1, we_n=1) with A[0]=0: next edge DO<=count of channel, OE<=1, ien<=A[2], that channel's flag<=0.
REQ-019 Read with A[0]=1: next edge DO<={zero-pad, flag[NUM_CH-1:0]}, OE<=1; no flag changes.
REQ-020 In any cycle without a read, OE<=0 and DO holds its last value.
REQ-021 Write and tick on the same channel same cycle: write wins.
REQ-022 Flag-clearing read and flag-setting tick same cycle: set wins, flag=1.
REQ-023 irq_n updates one cycle after flag/ien change; writes to other channels SHALL not affect a channel.
REQ-024 All counter arithmetic SHALL be modulo 2^CNT_W; prescale counter 10 bits.

Reset
REQ-025 While rst=1: all count, reload, flag, ien, mode=0; div=1; prescale counters=0; DO=0; OE=0; irq_n=1.
REQ-026 Reset mid-count SHALL abandon the count immediately; no flag or irq after release until a new write and expiry.

Structure
REQ-027 Package multi_timer_pkg SHALL hold prescale select enum, divider constants (1,8,64,1024), address field positions and the mode enum.
REQ-028 Per-channel counter/prescaler/flag logic SHALL be sub-module timer_channel, instantiated NUM_CH times; bus decode, read mux and irq_n stay in multi_timer.

Verification
REQ-029 Write ch0 DI=3, A=6'b000100 (div 1, ien, one-shot) -> count 3,2,1,0 on successive cycles, flag=1 and irq_n=0 on the edge after count 0, count=0xFF.
REQ-030 Write ch1 DI=2, div 8, auto-reload -> flag sets after 24 clks, count reloads to 2, period 24 repeats; status read returns 8'b0000_0010.
REQ-031 With ch0 flag set, read A=6'b000000 -> DO=count, OE=1 one cycle, flag=0, irq_n=1 next cycle; same read coincident with expiry -> flag stays 1.
REQ-032 Write ch2 on exact tick cycle of ch2 expiry -> flag=0, count=DI; ch3 unaffected.
REQ-033 Assert rst mid-count on all channels -> outputs and state at reset values same cycle (asynchronous); no irq until next write.
REQ-034 Repeat REQ-029 with CNT_W=16, DI=16'h0102 -> 259 ticks to flag, wrap to 16'hFFFF.
